lbp_hist: RTL and testbench



---
 rtl/lbp_hist.sv | 201 ++++++++++++++++++++
 tb/tb_lbp_hist.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - rotation-invariant uniform LBP histogram over an 8x8 code memory
// Build option: define LBP_HIST_BORDER_EN to scan all 64 addresses instead of the 36 interior ones.
module lbp_hist (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] lbp_addr,
    output logic       lbp_req,
    input  logic [7:0] lbp_data,
    output logic [3:0] hist_bin,
    output logic [6:0] hist_cnt,
    output logic       hist_valid,
    output logic       done
);

    localparam int NUM_BINS = 10;

`ifdef LBP_HIST_BORDER_EN
    localparam logic [5:0] FIRST_ADDR = 6'd0;
    localparam logic [5:0] LAST_ADDR  = 6'd63;
`else
    localparam logic [5:0] FIRST_ADDR = 6'd9;
    localparam logic [5:0] LAST_ADDR  = 6'd54;
`endif

    localparam logic [3:0] LAST_DUMP_IDX = 4'd9;
    localparam logic [6:0] CNT_MAX       = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] lbp_addr_q, lbp_addr_d;
    logic       lbp_req_q, lbp_req_d;
    logic [3:0] dump_idx_q, dump_idx_d;
    logic [3:0] hist_bin_q, hist_bin_d;
    logic [6:0] hist_cnt_q, hist_cnt_d;
    logic       hist_valid_q, hist_valid_d;
    logic       done_q, done_d;
    logic [6:0] bins_q [NUM_BINS];
    logic [6:0] bins_d [NUM_BINS];

    logic [3:0] code_bin;
    logic [6:0] dump_cnt;

    // Raster step through the scanned window; interior mode wraps x from 6 back to 1 on the next row.
    function automatic logic [5:0] next_addr(input logic [5:0] a);
`ifdef LBP_HIST_BORDER_EN
        return a + 6'd1;
`else
        if (a[2:0] == 3'd6) begin
            return {a[5:3] + 3'd1, 3'd1};
        end
        return a + 6'd1;
`endif
    endfunction

    // Uniform codes (at most two 0/1 transitions around the neighbour ring) map to their popcount, others to bin 9.
    function automatic logic [3:0] classify(input logic [7:0] b);
        logic [7:0] ring;
        logic [7:0] diff;
        logic [3:0] trans;
        logic [3:0] ones;
        // ring[0..7] walks TL, TM, TR, MR, BR, BM, BL, ML
        ring  = {b[3], b[5], b[6], b[7], b[4], b[2], b[1], b[0]};
        // diff[i] compares ring[i] with its successor; diff[7] is the wrap pair ML -> TL
        diff  = ring ^ {ring[0], ring[7:1]};
        trans = 4'd0;
        ones  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            trans = trans + {3'd0, diff[i]};
            ones  = ones + {3'd0, b[i]};
        end
        if (trans <= 4'd2) begin
            return ones;
        end
        return 4'd9;
    endfunction

    // Bin of the code returned by memory this cycle, and the counter selected for the current dump beat.
    always_comb begin
        code_bin = classify(lbp_data);
        dump_cnt = 7'd0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (dump_idx_q == 4'(i)) begin
                dump_cnt = bins_q[i];
            end
        end
    end

    // Control FSM: start scan, accumulate one code per cycle, then stream the ten bins.
    always_comb begin
        state_d      = state_q;
        lbp_addr_d   = lbp_addr_q;
        lbp_req_d    = lbp_req_q;
        dump_idx_d   = dump_idx_q;
        hist_bin_d   = hist_bin_q;
        hist_cnt_d   = hist_cnt_q;
        hist_valid_d = hist_valid_q;
        done_d       = done_q;
        for (int i = 0; i < NUM_BINS; i++) begin
            bins_d[i] = bins_q[i];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_SCAN;
                    lbp_addr_d   = FIRST_ADDR;
                    lbp_req_d    = 1'b1;
                    dump_idx_d   = 4'd0;
                    hist_bin_d   = 4'd0;
                    hist_cnt_d   = 7'd0;
                    hist_valid_d = 1'b0;
                    done_d       = 1'b0;
                    for (int i = 0; i < NUM_BINS; i++) begin
                        bins_d[i] = 7'd0;
                    end
                end
            end

            ST_SCAN: begin
                // lbp_data belongs to the address driven this cycle
                for (int i = 0; i < NUM_BINS; i++) begin
                    if (code_bin == 4'(i) && bins_q[i] != CNT_MAX) begin
                        bins_d[i] = bins_q[i] + 7'd1;
                    end
                end
                if (lbp_addr_q == LAST_ADDR) begin
                    state_d    = ST_DUMP;
                    lbp_req_d  = 1'b0;
                    lbp_addr_d = 6'd0;
                    dump_idx_d = 4'd0;
                end else begin
                    lbp_addr_d = next_addr(lbp_addr_q);
                end
            end

            ST_DUMP: begin
                // dump_idx runs one past the last bin so that done follows the final beat by a cycle
                if (dump_idx_q > LAST_DUMP_IDX) begin
                    state_d      = ST_DONE;
                    hist_valid_d = 1'b0;
                    hist_bin_d   = 4'd0;
                    hist_cnt_d   = 7'd0;
                    done_d       = 1'b1;
                end else begin
                    hist_valid_d = 1'b1;
                    hist_bin_d   = dump_idx_q;
                    hist_cnt_d   = dump_cnt;
                    dump_idx_d   = dump_idx_q + 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lbp_addr_q   <= 6'd0;
            lbp_req_q    <= 1'b0;
            dump_idx_q   <= 4'd0;
            hist_bin_q   <= 4'd0;
            hist_cnt_q   <= 7'd0;
            hist_valid_q <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= 7'd0;
            end
        end else begin
            state_q      <= state_d;
            lbp_addr_q   <= lbp_addr_d;
            lbp_req_q    <= lbp_req_d;
            dump_idx_q   <= dump_idx_d;
            hist_bin_q   <= hist_bin_d;
            hist_cnt_q   <= hist_cnt_d;
            hist_valid_q <= hist_valid_d;
            done_q       <= done_d;
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= bins_d[i];
            end
        end
    end

    assign lbp_addr   = lbp_addr_q;
    assign lbp_req    = lbp_req_q;
    assign hist_bin   = hist_bin_q;
    assign hist_cnt   = hist_cnt_q;
    assign hist_valid = hist_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - self-checking bench for lbp_hist (honours LBP_HIST_BORDER_EN)
module tb_lbp_hist;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] lbp_addr;
    logic       lbp_req;
    logic [7:0] lbp_data;
    logic [3:0] hist_bin;
    logic [6:0] hist_cnt;
    logic       hist_valid;
    logic       done;

    lbp_hist dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lbp_addr  (lbp_addr),
        .lbp_req   (lbp_req),
        .lbp_data  (lbp_data),
        .hist_bin  (hist_bin),
        .hist_cnt  (hist_cnt),
        .hist_valid(hist_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

`ifdef LBP_HIST_BORDER_EN
    localparam int LO = 0;
    localparam int HI = 7;
`else
    localparam int LO = 1;
    localparam int HI = 6;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem [64];
    int         scan_q[$];
    int         ns;
    int         got_h [10];

    typedef struct {
        logic [7:0] code;
        int         exp_bin;
    } vec_t;

    vec_t tbl [10];

    // Memory model: contents change on the falling edge, stable at the next rising edge.
    always @(negedge clk) lbp_data = mem[lbp_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Rotation-invariant uniform patterns are exactly the rotations of a contiguous run of k ones.
    function automatic int ref_bin(input logic [7:0] code);
        int         nb [8] = '{0, 1, 2, 4, 7, 6, 5, 3};
        logic [7:0] ring;
        logic [7:0] base;
        logic [7:0] rot;
        for (int i = 0; i < 8; i++) ring[i] = code[nb[i]];
        for (int k = 0; k <= 8; k++) begin
            base = 8'((16'd1 << k) - 16'd1);
            for (int r = 0; r < 8; r++) begin
                rot = 8'((16'(base) << r) | (16'(base) >> (8 - r)));
                if (rot == ring) return $countones(code);
            end
        end
        return 9;
    endfunction

    task automatic check_hist(input string tag);
        int exp_h [10];
        int b;
        for (int i = 0; i < 10; i++) exp_h[i] = 0;
        foreach (scan_q[j]) begin
            b = ref_bin(mem[scan_q[j]]);
            if (exp_h[b] < 127) exp_h[b]++;
        end
        for (int i = 0; i < 10; i++) chk($sformatf("%s bin%0d", tag, i), got_h[i], exp_h[i]);
    endtask

    // Drives (or reuses) a start, then checks every cycle of scan and dump against the timing rules.
    task automatic run_scan(input bit hold, input bit skip_start);
        int last;
        bit exp_v;
        last = ns + 12;
        for (int i = 0; i < 10; i++) got_h[i] = -1;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk($sformatf("lbp_req c%0d", c), int'(lbp_req), int'(c <= ns));
            if (c <= ns) chk($sformatf("lbp_addr c%0d", c), int'(lbp_addr), scan_q[c-1]);
            exp_v = (c >= ns + 2) && (c <= ns + 11);
            chk($sformatf("hist_valid c%0d", c), int'(hist_valid), int'(exp_v));
            if (exp_v) chk($sformatf("hist_bin c%0d", c), int'(hist_bin), c - ns - 2);
            if (hist_valid && hist_bin < 4'd10) got_h[hist_bin] = int'(hist_cnt);
            chk($sformatf("done c%0d", c), int'(done), int'(c >= ns + 12));
            if (c < last) @(posedge clk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " lbp_addr"}, int'(lbp_addr), 0);
        chk({tag, " lbp_req"}, int'(lbp_req), 0);
        chk({tag, " hist_bin"}, int'(hist_bin), 0);
        chk({tag, " hist_cnt"}, int'(hist_cnt), 0);
        chk({tag, " hist_valid"}, int'(hist_valid), 0);
        chk({tag, " done"}, int'(done), 0);
    endtask

    initial begin
        int j;
        int bad;

        tbl[0] = '{8'h00, 0};
        tbl[1] = '{8'hFF, 8};
        tbl[2] = '{8'h07, 3};
        tbl[3] = '{8'h55, 9};
        tbl[4] = '{8'h01, 1};
        tbl[5] = '{8'h0B, 3};
        tbl[6] = '{8'h02, 1};
        tbl[7] = '{8'h5A, 9};
        tbl[8] = '{8'h16, 3};
        tbl[9] = '{8'h81, 9};

        for (int y = LO; y <= HI; y++)
            for (int x = LO; x <= HI; x++) scan_q.push_back(y * 8 + x);
        ns = scan_q.size();

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        lbp_data = 8'h00;
        reset    = 1'b1;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Uniform fills: every scanned code lands in one bin.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = tbl[t].code;
            run_scan(1'b0, 1'b0);
            for (int b = 0; b < 10; b++)
                chk($sformatf("fill%02h bin%0d", tbl[t].code, b), got_h[b], (b == tbl[t].exp_bin) ? ns : 0);
        end

        // done holds with no beats while start stays low.
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!done || hist_valid) bad++;
        end
        chk("done held idle", bad, 0);

        // Interior alternating 0x07 / 0x55, border zero.
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        j = 0;
        for (int y = 1; y <= 6; y++)
            for (int x = 1; x <= 6; x++) begin
                mem[y * 8 + x] = (j % 2 == 0) ? 8'h07 : 8'h55;
                j++;
            end
        run_scan(1'b0, 1'b0);
        check_hist("alt");
        chk("alt bin3", got_h[3], 18);
        chk("alt bin9", got_h[9], 18);

        // Random codes against the reference model.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            run_scan(1'b0, 1'b0);
            check_hist($sformatf("rand%0d", r));
        end

        // start held high: no restart mid-operation, then an immediate rescan that recomputes.
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        run_scan(1'b1, 1'b0);
        check_hist("hold1");
        run_scan(1'b1, 1'b1);
        start = 1'b0;
        check_hist("hold2");

        // Reset at cycle 10 of a scan aborts everything.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (hist_valid || done || lbp_req) bad++;
        end
        chk("quiet after reset", bad, 0);

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        run_scan(1'b0, 1'b0);
        check_hist("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
